// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions for the RV32 core.
// Contents: sequencer state enum, major opcode constants and a load-use helper.
// Users: hazard_sequencer, the decode control unit and the iterative CTZ unit.
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } seq_state_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_CTZ    = 7'b1110011;

   // x0 is never a real dependency, so a load targeting it cannot stall.
   function automatic logic load_use_f(
      input logic       ex_mem_read,
      input logic [4:0] ex_rd,
      input logic [4:0] id_rs1,
      input logic [4:0] id_rs2,
      input logic       id_uses_rs1,
      input logic       id_uses_rs2
   );
      return ex_mem_read && (ex_rd != 5'd0) &&
             ((id_uses_rs1 && (ex_rd == id_rs1)) ||
              (id_uses_rs2 && (ex_rd == id_rs2)));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, reset (async, active high), inc (count enable),
//        clr (sync clear, wins over inc), q (count value).
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc && (q_q != {W{1'b1}})) begin
         q_d = q_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: stall/hold/flush strobes for PC, IF/ID, ID/EX
// and EX/MEM; start/done handshake with timeout for the multi-cycle CTZ op;
// saturating stall and flush performance counters.
// Inputs : clk, reset, ID source regs/uses, EX rd/load/multicycle/redirect,
//          mc_done, perf_clr.
// Outputs: pc_write, ifid_write, idex_write, ifid_flush, idex_flush,
//          exmem_flush, mc_start, mc_err, stall_cnt, flush_cnt.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal flow; resolves CTZ start, redirect and load-use
// MC_WAIT | CTZ in flight; pipeline held, EX/MEM bubbled until done/timeout
module hazard_sequencer
   import pipe_ctrl_pkg::*;
#(
   parameter int MC_TIMEOUT = 64,
   parameter int TO_W       = 7,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memRead,
   input  logic             ex_multicycle,
   input  logic             ex_redirect,
   input  logic             mc_done,
   input  logic             perf_clr,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             mc_start,
   output logic             mc_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);

   seq_state_e      state_q, state_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            mc_err_q, mc_err_d;
   logic            load_use;
   logic            stall_inc;
   logic            flush_inc;

   assign load_use = load_use_f(ex_memRead, ex_rd, id_rs1, id_rs2,
                                id_uses_rs1, id_uses_rs2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= RUN;
         to_cnt_q <= '0;
         mc_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         to_cnt_q <= to_cnt_d;
         mc_err_q <= mc_err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      to_cnt_d = to_cnt_q;
      mc_err_d = mc_err_q;
      case (state_q)
         RUN: begin
            if (ex_multicycle) begin
               state_d  = MC_WAIT;
               to_cnt_d = '0;
            end
         end
         MC_WAIT: begin
            if (mc_done) begin
               state_d = RUN;
            end else if (to_cnt_q == TO_LAST) begin
               state_d  = RUN;
               mc_err_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Outputs are forced to their RUN/no-hazard values while reset is high so
   // an in-flight CTZ cannot re-issue mc_start during reset.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      mc_start    = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      if (!reset) begin
         case (state_q)
            RUN: begin
               if (ex_multicycle) begin
                  mc_start    = 1'b1;
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_write  = 1'b0;
                  exmem_flush = 1'b1;
               end else if (ex_redirect) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  flush_inc  = 1'b1;
               end else if (load_use) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  idex_flush = 1'b1;
                  stall_inc  = 1'b1;
               end
            end
            MC_WAIT: begin
               // Done and timeout cycles release the pipeline with defaults.
               if (!mc_done && (to_cnt_q != TO_LAST)) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_write  = 1'b0;
                  exmem_flush = 1'b1;
                  stall_inc   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mc_err = mc_err_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .clr   (perf_clr),
      .q     (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_inc),
      .clr   (perf_clr),
      .q     (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer (MC_TIMEOUT=8, CNT_W=4).
module tb_hazard_sequencer;
   import pipe_ctrl_pkg::*;

   localparam int MC_TIMEOUT = 8;
   localparam int TO_W       = 7;
   localparam int CNT_W      = 4;

   // Strobe vector order: pc_write, ifid_write, idex_write, ifid_flush,
   // idex_flush, exmem_flush, mc_start
   localparam logic [6:0] S_DEF   = 7'b1110000;
   localparam logic [6:0] S_LU    = 7'b0010100;
   localparam logic [6:0] S_RDIR  = 7'b1111100;
   localparam logic [6:0] S_START = 7'b0000011;
   localparam logic [6:0] S_WAIT  = 7'b0000010;

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       id_rs1, id_rs2, ex_rd;
   logic             id_uses_rs1, id_uses_rs2;
   logic             ex_memRead, ex_multicycle, ex_redirect, mc_done, perf_clr;
   logic             pc_write, ifid_write, idex_write;
   logic             ifid_flush, idex_flush, exmem_flush, mc_start, mc_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [6:0]       strobes;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_sequencer #(
      .MC_TIMEOUT (MC_TIMEOUT),
      .TO_W       (TO_W),
      .CNT_W      (CNT_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_uses_rs1   (id_uses_rs1),
      .id_uses_rs2   (id_uses_rs2),
      .ex_rd         (ex_rd),
      .ex_memRead    (ex_memRead),
      .ex_multicycle (ex_multicycle),
      .ex_redirect   (ex_redirect),
      .mc_done       (mc_done),
      .perf_clr      (perf_clr),
      .pc_write      (pc_write),
      .ifid_write    (ifid_write),
      .idex_write    (idex_write),
      .ifid_flush    (ifid_flush),
      .idex_flush    (idex_flush),
      .exmem_flush   (exmem_flush),
      .mc_start      (mc_start),
      .mc_err        (mc_err),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   assign strobes = {pc_write, ifid_write, idex_write, ifid_flush,
                     idex_flush, exmem_flush, mc_start};

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_rd = 5'd0; ex_memRead = 1'b0; ex_multicycle = 1'b0;
      ex_redirect = 1'b0; mc_done = 1'b0; perf_clr = 1'b0;
   endtask

   // lw x5 in EX, add x6,x5,x7 in ID
   task automatic set_load_use();
      ex_memRead = 1'b1; ex_rd = 5'd5;
      id_rs1 = 5'd5; id_rs2 = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      #1;
      chk("rst_strobes", 32'(strobes), 32'(S_DEF));
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      chk("rst_mc_err", 32'(mc_err), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Load-use on rs1
      set_load_use();
      #1;
      chk("lu_rs1_strobes", 32'(strobes), 32'(S_LU));
      tick();
      idle();
      #1;
      chk("lu_after_strobes", 32'(strobes), 32'(S_DEF));
      chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

      // Load-use on rs2
      ex_memRead = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd5; id_rs2 = 5'd7;
      id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
      #1;
      chk("lu_rs2_strobes", 32'(strobes), 32'(S_LU));
      tick();

      // rs2 matches but is not read: no hazard
      id_uses_rs2 = 1'b0;
      #1;
      chk("lu_rs2_unused", 32'(strobes), 32'(S_DEF));
      tick();
      chk("lu_rs2_cnt", 32'(stall_cnt), 32'd2);

      // Load to x0: no hazard
      idle();
      ex_memRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
      #1;
      chk("lu_x0_strobes", 32'(strobes), 32'(S_DEF));
      tick();
      chk("lu_x0_cnt", 32'(stall_cnt), 32'd2);

      // Clear counters
      idle();
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
      chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);

      // Redirect together with load-use: flush wins
      set_load_use();
      ex_redirect = 1'b1;
      #1;
      chk("rdir_strobes", 32'(strobes), 32'(S_RDIR));
      tick();
      idle();
      #1;
      chk("rdir_flush_cnt", 32'(flush_cnt), 32'd1);
      chk("rdir_stall_cnt", 32'(stall_cnt), 32'd0);
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;

      // CTZ, mc_done five cycles after mc_start
      ex_multicycle = 1'b1;
      #1;
      chk("ctz_start", 32'(strobes), 32'(S_START));
      tick();
      for (int i = 0; i < 4; i++) begin
         ex_redirect = (i == 1);
         set_load_use();
         #1;
         chk($sformatf("ctz_wait%0d", i), 32'(strobes), 32'(S_WAIT));
         tick();
      end
      idle();
      ex_multicycle = 1'b1;
      mc_done = 1'b1;
      #1;
      chk("ctz_done_strobes", 32'(strobes), 32'(S_DEF));
      tick();
      idle();
      #1;
      chk("ctz_stall_cnt", 32'(stall_cnt), 32'd4);
      chk("ctz_flush_cnt", 32'(flush_cnt), 32'd0);
      chk("ctz_run_strobes", 32'(strobes), 32'(S_DEF));
      chk("ctz_mc_err", 32'(mc_err), 32'd0);

      // mc_done in RUN is ignored; a CTZ right after still starts
      mc_done = 1'b1;
      #1;
      chk("run_done_ignored", 32'(strobes), 32'(S_DEF));
      tick();
      idle();
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;

      // CTZ timeout: 7 held cycles, then the 8th releases with mc_err
      ex_multicycle = 1'b1;
      #1;
      chk("to_start", 32'(strobes), 32'(S_START));
      tick();
      for (int i = 0; i < MC_TIMEOUT - 1; i++) begin
         chk($sformatf("to_wait%0d", i), 32'(strobes), 32'(S_WAIT));
         tick();
      end
      chk("to_exit_strobes", 32'(strobes), 32'(S_DEF));
      chk("to_err_before", 32'(mc_err), 32'd0);
      tick();
      chk("to_mc_err", 32'(mc_err), 32'd1);
      chk("to_stall_cnt", 32'(stall_cnt), 32'd7);
      chk("to_restart", 32'(strobes), 32'(S_START));
      tick();
      mc_done = 1'b1;
      #1;
      chk("to2_done", 32'(strobes), 32'(S_DEF));
      tick();
      idle();
      tick();
      chk("to_err_sticky", 32'(mc_err), 32'd1);

      // Reset two cycles into MC_WAIT; multicycle + redirect counts no flush
      ex_multicycle = 1'b1;
      ex_redirect = 1'b1;
      #1;
      chk("mcr_strobes", 32'(strobes), 32'(S_START));
      tick();
      ex_redirect = 1'b0;
      chk("mcr_flush_cnt", 32'(flush_cnt), 32'd0);
      tick();
      tick();
      chk("rst_mc_pre", 32'(strobes), 32'(S_WAIT));
      reset = 1'b1;
      #1;
      chk("rst_mc_strobes", 32'(strobes), 32'(S_DEF));
      chk("rst_mc_stall", 32'(stall_cnt), 32'd0);
      chk("rst_mc_err", 32'(mc_err), 32'd0);
      tick();
      chk("rst_mc_hold", 32'(strobes), 32'(S_DEF));
      reset = 1'b0;
      ex_multicycle = 1'b0;
      #1;
      chk("rst_mc_run", 32'(strobes), 32'(S_DEF));
      tick();
      ex_multicycle = 1'b1;
      #1;
      chk("rst_mc_restart", 32'(strobes), 32'(S_START));
      tick();
      mc_done = 1'b1;
      tick();
      idle();

      // Saturation with 20 load-use stalls
      for (int i = 0; i < 20; i++) begin
         set_load_use();
         tick();
         if (i == 14) chk("sat_15", 32'(stall_cnt), 32'd15);
      end
      chk("sat_20", 32'(stall_cnt), 32'd15);
      perf_clr = 1'b1;
      #1;
      chk("clr_lu_strobes", 32'(strobes), 32'(S_LU));
      tick();
      chk("clr_over_inc", 32'(stall_cnt), 32'd0);
      idle();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Pipeline control sequencer for the 5-stage RV32 core, placed beside the decode control unit. Generates stall, hold and flush strobes for the PC, IF/ID, ID/EX and EX/MEM registers. Covers three cases: load-use hazards, taken branches and jumps resolved in EX, and the multi-cycle custom CTZ op (opcode 7'b1110011), which it runs through a start/done handshake with timeout. Also keeps saturating performance counters for stalls and flushes.

Parameters:
MC_TIMEOUT, 64, maximum cycles spent in MC_WAIT before forced exit; legal range 2..2^TO_W-1
TO_W, 7, width of the timeout counter
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high reset
id_rs1  in  5  rs1 of the instruction in ID
id_rs2  in  5  rs2 of the instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination register of the instruction in EX
ex_memRead  in  1  EX instruction is a load
ex_multicycle  in  1  EX instruction is CTZ (multi-cycle)
ex_redirect  in  1  taken branch or jump resolved in EX
mc_done  in  1  one-cycle pulse from the iterative unit: result valid
perf_clr  in  1  synchronous clear of both performance counters
pc_write  out  1  PC enable
ifid_write  out  1  IF/ID enable
idex_write  out  1  ID/EX enable (low = hold EX)
ifid_flush  out  1  squash IF/ID
idex_flush  out  1  load a bubble into ID/EX
exmem_flush  out  1  load a bubble into EX/MEM
mc_start  out  1  one-cycle start pulse to the iterative unit
mc_err  out  1  sticky flag: MC_WAIT timed out
stall_cnt  out  CNT_W  saturating count of stalled cycles
flush_cnt  out  CNT_W  saturating count of redirect events

Behaviour:
- States: RUN, MC_WAIT. Reset state is RUN.
- On reset: stall_cnt=0, flush_cnt=0, mc_err=0, timeout counter=0.
- Strobe outputs are combinational from state and inputs. While reset is high, mc_start=0 and the outputs take their RUN/no-hazard values.
- Default (RUN, no event): all write enables 1, all flushes 0, mc_start 0.
- load_use = ex_memRead & (ex_rd!=0) & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- Priority in RUN, highest first:
  1. ex_multicycle: mc_start=1, pc_write=0, ifid_write=0, idex_write=0, exmem_flush=1; next state MC_WAIT; timeout counter cleared.
  2. ex_redirect: ifid_flush=1, idex_flush=1, pc_write=1; flush_cnt+1.
  3. load_use: pc_write=0, ifid_write=0, idex_flush=1 for exactly that cycle; stall_cnt+1.
  - ex_multicycle together with ex_redirect is illegal; rule 1 wins and no flush is counted.
  - ex_redirect together with load_use: the flush wins and the stall is not counted.
- MC_WAIT:
  - While mc_done=0: pc_write, ifid_write and idex_write are 0, exmem_flush=1, stall_cnt+1 per cycle, timeout counter+1.
  - mc_done=1: default outputs that cycle (the pipeline advances and the result enters EX/MEM); next state RUN; the cycle is not counted as a stall.
  - Timeout counter reaching MC_TIMEOUT-1 with mc_done=0: set mc_err (sticky until reset), default outputs that cycle, next state RUN.
  - ex_redirect and load_use are ignored in MC_WAIT. mc_start is never reasserted in MC_WAIT.
- mc_done in RUN is ignored.
- Latency: mc_start is asserted in the first EX cycle of CTZ. The earliest mc_done is the next cycle, giving a minimum CTZ occupancy of 2 cycles.
- Counters saturate at 2^CNT_W-1. perf_clr has priority over an increment in the same cycle.
- Asynchronous reset during MC_WAIT: immediate return to RUN; mc_start stays low; the iterative unit is reset by the same signal.

Decomposition:
- Package pipe_ctrl_pkg holds the state enum {RUN, MC_WAIT} and the opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_CTZ). The decode control unit and the iterative CTZ unit share the package.
- One sub-module: sat_counter (parameter W; ports inc, clr, q), instantiated twice.

Test Plan:
- Load x5, then add x6,x5,x7 in ID -> exactly 1 cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_cnt=1. Same sequence with rd=x0 -> no stall.
- ex_redirect=1 for 1 cycle while load_use is also true -> ifid_flush=idex_flush=1, pc_write=1; flush_cnt=1, stall_cnt=0.
- ex_multicycle=1, mc_done pulsed 5 cycles after mc_start -> one mc_start pulse; 4 MC_WAIT cycles with exmem_flush=1 and pipeline held; stall_cnt=4; RUN with default outputs on the done cycle.
- MC_TIMEOUT=8, mc_done never asserted -> exit to RUN after 8 MC_WAIT cycles; mc_err=1 and stays 1; a following CTZ still pulses mc_start.
- Reset asserted 2 cycles into MC_WAIT -> state RUN, counters 0, mc_err 0 immediately; no mc_start until ex_multicycle is seen again after reset falls.
- CNT_W=4 with 20 load-use stalls -> stall_cnt holds at 15; perf_clr together with a stall -> 0.
